bus_write_checker: RTL

Synthesizable, parametrised self-check block for the multicycle ARM-with-bus system. It observes the core's data-bus write strobe, address and write data, and compares every write against a parameter table of expected (address, data) pairs. Writes to listed scratch addresses are ignored, and a cycle budget is enforced. It reports a sticky pass/fail verdict with a diagnostic code, and it can be used in simulation benches or on FPGA with the status driven to LEDs.

---
 rtl/bus_chk_pkg.sv | 25 ++
 rtl/write_matcher.sv | 52 +++++
 rtl/bus_write_checker.sv | 116 +++++++++++
 3 files changed

// File: rtl/bus_chk_pkg.sv
// Shared types for the bus write checker: FSM states, verdict codes and a
// small width helper used for table indices.
package bus_chk_pkg;

  localparam int FAIL_CODE_W = 3;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PASS = 2'd1,
    ST_FAIL = 2'd2
  } chk_state_t;

  typedef enum logic [FAIL_CODE_W-1:0] {
    FC_NONE     = 3'd0,
    FC_BAD_ADDR = 3'd1,
    FC_BAD_DATA = 3'd2,
    FC_TIMEOUT  = 3'd3
  } fail_code_t;

  // Index width that stays at least one bit for single-entry tables.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/write_matcher.sv
// Combinational lookup of one bus write against the expected-write table
// and the ignore list. Table entry 0 sits in the most significant slice.
module write_matcher
  import bus_chk_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int N_EXP   = 4,
  parameter int N_IGN   = 1,
  parameter bit ORDERED = 1'b1,
  localparam int MC_W   = $clog2(N_EXP + 1),
  localparam int IDX_W  = idx_w(N_EXP)
) (
  input  logic [ADDR_W-1:0]       data_adr,
  input  logic [DATA_W-1:0]       write_data,
  input  logic [N_EXP*ADDR_W-1:0] exp_addr,
  input  logic [N_EXP*DATA_W-1:0] exp_data,
  input  logic [N_IGN*ADDR_W-1:0] ign_addr,
  input  logic [N_EXP-1:0]        matched,
  input  logic [MC_W-1:0]         match_cnt,
  output logic                    hit,
  output logic                    data_ok,
  output logic [IDX_W-1:0]        hit_idx,
  output logic                    ignored
);

  always_comb begin
    logic cand;
    hit     = 1'b0;
    data_ok = 1'b0;
    hit_idx = '0;
    ignored = 1'b0;
    cand    = 1'b0;
    // Ordered mode only offers the next table entry; unordered mode offers
    // every unmatched entry and the lowest index wins.
    for (int i = 0; i < N_EXP; i++) begin
      cand = ORDERED ? (i == int'(match_cnt)) : !matched[i];
      if (!hit && cand &&
          exp_addr[(N_EXP-1-i)*ADDR_W +: ADDR_W] == data_adr) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
        data_ok = (exp_data[(N_EXP-1-i)*DATA_W +: DATA_W] == write_data);
      end
    end
    for (int j = 0; j < N_IGN; j++) begin
      if (ign_addr[(N_IGN-1-j)*ADDR_W +: ADDR_W] == data_adr) begin
        ignored = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_write_checker.sv
// Watches data-bus writes, checks them against an expected (address, data)
// table under a cycle budget, and latches a sticky PASS/FAIL verdict.
module bus_write_checker
  import bus_chk_pkg::*;
#(
  parameter int                      ADDR_W   = 32,
  parameter int                      DATA_W   = 32,
  parameter int                      N_EXP    = 4,
  parameter logic [N_EXP*ADDR_W-1:0] EXP_ADDR = {N_EXP{ADDR_W'(100)}},
  parameter logic [N_EXP*DATA_W-1:0] EXP_DATA = {N_EXP{DATA_W'(7)}},
  parameter int                      N_IGN    = 1,
  parameter logic [N_IGN*ADDR_W-1:0] IGN_ADDR = {ADDR_W'(96)},
  parameter bit                      ORDERED  = 1'b1,
  parameter int                      TIMEOUT  = 10000,
  parameter int                      CNT_W    = 32,
  localparam int                     MC_W     = $clog2(N_EXP + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mem_write,
  input  logic [ADDR_W-1:0]      data_adr,
  input  logic [DATA_W-1:0]      write_data,
  output logic                   done,
  output logic                   pass,
  output logic [FAIL_CODE_W-1:0] fail_code,
  output logic [ADDR_W-1:0]      fail_adr,
  output logic [DATA_W-1:0]      fail_data,
  output logic [MC_W-1:0]        match_cnt,
  output logic [CNT_W-1:0]       cycle_cnt
);

  localparam int IDX_W = idx_w(N_EXP);

  chk_state_t         state;
  logic [N_EXP-1:0]   matched;
  logic               hit;
  logic               data_ok;
  logic [IDX_W-1:0]   hit_idx;
  logic               ignored;
  logic               timeout_now;
  logic               last_match;

  write_matcher #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .N_EXP  (N_EXP),
    .N_IGN  (N_IGN),
    .ORDERED(ORDERED)
  ) u_matcher (
    .data_adr  (data_adr),
    .write_data(write_data),
    .exp_addr  (EXP_ADDR),
    .exp_data  (EXP_DATA),
    .ign_addr  (IGN_ADDR),
    .matched   (matched),
    .match_cnt (match_cnt),
    .hit       (hit),
    .data_ok   (data_ok),
    .hit_idx   (hit_idx),
    .ignored   (ignored)
  );

  assign timeout_now = (TIMEOUT != 0) && (cycle_cnt == CNT_W'(TIMEOUT - 1));
  assign last_match  = (match_cnt == MC_W'(N_EXP - 1));

  // mem_write is a single-cycle strobe: every posedge with it high is one
  // write, there is no back-pressure. A write on the timeout edge decides
  // the verdict first; only a harmless write lets the timeout through.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_RUN;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_code <= FC_NONE;
      fail_adr  <= '0;
      fail_data <= '0;
      match_cnt <= '0;
      cycle_cnt <= '0;
      matched   <= '0;
    end else if (state == ST_RUN) begin
      if (cycle_cnt != {CNT_W{1'b1}}) begin
        cycle_cnt <= cycle_cnt + CNT_W'(1);
      end
      if (mem_write && hit && data_ok) begin
        matched   <= matched | (N_EXP'(1) << hit_idx);
        match_cnt <= match_cnt + MC_W'(1);
        if (last_match) begin
          state <= ST_PASS;
          done  <= 1'b1;
          pass  <= 1'b1;
        end else if (timeout_now) begin
          state     <= ST_FAIL;
          done      <= 1'b1;
          fail_code <= FC_TIMEOUT;
        end
      end else if (mem_write && hit) begin
        state     <= ST_FAIL;
        done      <= 1'b1;
        fail_code <= FC_BAD_DATA;
        fail_adr  <= data_adr;
        fail_data <= write_data;
      end else if (mem_write && !ignored) begin
        state     <= ST_FAIL;
        done      <= 1'b1;
        fail_code <= FC_BAD_ADDR;
        fail_adr  <= data_adr;
        fail_data <= write_data;
      end else if (timeout_now) begin
        state     <= ST_FAIL;
        done      <= 1'b1;
        fail_code <= FC_TIMEOUT;
      end
    end
  end

endmodule
